// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared definitions for the Femto two-read/one-write register file:
//   - rf_state_t : clear-sequencer states (RF_IDLE, RF_CLEAR)
//   - rf_depth() : number of entries for a given address width
//   - NUMRF_DEF / SIZE_DEF : default address and data widths
package reg_file_pkg;

    localparam int NUMRF_DEF = 2;
    localparam int SIZE_DEF  = 8;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    function automatic int rf_depth(input int numrf);
        return 1 << numrf;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if
// Bus between the instruction decoder (master) and the register file (slave).
//   master drives : clr, wr, reg_in, data_in, rd_a, rd_b, reg_a, reg_b
//   slave drives  : data_a, data_b, busy, wr_drop, dbg_state, dbg_ptr
//
// Handshake: there is no backpressure. A write (wr=1) is taken on the rising
// edge only while the file is idle and clr=0; otherwise it is discarded and
// wr_drop pulses high for the following cycle. busy=1 marks the clear walk,
// during which both read ports return zero. dbg_state/dbg_ptr expose the
// clear sequencer for observation only.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int NUMRF = NUMRF_DEF,
    parameter int SIZE  = SIZE_DEF
) ();

    logic             clr;
    logic             wr;
    logic [NUMRF-1:0] reg_in;
    logic [SIZE-1:0]  data_in;
    logic             rd_a;
    logic             rd_b;
    logic [NUMRF-1:0] reg_a;
    logic [NUMRF-1:0] reg_b;
    logic [SIZE-1:0]  data_a;
    logic [SIZE-1:0]  data_b;
    logic             busy;
    logic             wr_drop;
    rf_state_t        dbg_state;
    logic [NUMRF-1:0] dbg_ptr;

    modport master (
        output clr, wr, reg_in, data_in, rd_a, rd_b, reg_a, reg_b,
        input  data_a, data_b, busy, wr_drop, dbg_state, dbg_ptr
    );

    modport slave (
        input  clr, wr, reg_in, data_in, rd_a, rd_b, reg_a, reg_b,
        output data_a, data_b, busy, wr_drop, dbg_state, dbg_ptr
    );

endinterface

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq
// Clear sequencer: walks ptr over every entry after reset release or a clr
// request, asking the storage array to zero entry[ptr] each cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the clear walk
//   state, ptr : sequencer state (also used for debug)
//   busy       : registered, high exactly while state is RF_CLEAR
//   clr_we     : zero-write strobe to the storage array
//   clr_addr   : entry being zeroed
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int NUMRF = NUMRF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output rf_state_t        state,
    output logic [NUMRF-1:0] ptr,
    output logic             busy,
    output logic             clr_we,
    output logic [NUMRF-1:0] clr_addr
);

    localparam int               DEPTH = rf_depth(NUMRF);
    localparam logic [NUMRF-1:0] LAST  = NUMRF'(DEPTH - 1);

    rf_state_t        state_n;
    logic [NUMRF-1:0] ptr_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RF_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            // busy tracks the next state so it falls on the same edge that
            // leaves RF_CLEAR and rises on the edge that samples clr.
            busy  <= (state_n == RF_CLEAR);
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        case (state)
            RF_CLEAR: begin
                if (clr) begin
                    ptr_n = '0;
                end else if (ptr == LAST) begin
                    state_n = RF_IDLE;
                    ptr_n   = '0;
                end else begin
                    ptr_n = ptr + NUMRF'(1);
                end
            end
            RF_IDLE: begin
                if (clr) begin
                    state_n = RF_CLEAR;
                    ptr_n   = '0;
                end
            end
        endcase
    end

    // Storage must not change while reset is held.
    assign clr_we   = rst_n && (state == RF_CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp
// Two-read/one-write flop register file with a hardware clear sequencer.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : reg_file_if.slave (write port, two read ports, busy, wr_drop,
//           sequencer debug)
// Build option: define REG_FILE_BYPASS_EN to forward data_in to a read port
// reading the address being written in the same cycle.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int NUMRF = NUMRF_DEF,
    parameter int SIZE  = SIZE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);

    localparam int DEPTH = rf_depth(NUMRF);

    logic [SIZE-1:0]  mem [DEPTH];
    rf_state_t        state;
    logic [NUMRF-1:0] ptr;
    logic             busy;
    logic             clr_we;
    logic [NUMRF-1:0] clr_addr;
    logic             user_we;
    logic             wr_drop_q;
    logic [SIZE-1:0]  data_a;
    logic [SIZE-1:0]  data_b;

    reg_file_clr_seq #(.NUMRF(NUMRF)) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.clr),
        .state    (state),
        .ptr      (ptr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign user_we = rst_n && (state == RF_IDLE) && bus.wr && !bus.clr;

    // Clear writes win over user writes; both never coexist in practice
    // since user_we requires RF_IDLE.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_we) begin
            mem[bus.reg_in] <= bus.data_in;
        end
    end

    // A write lost to reset is not reported.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= bus.wr && ((state == RF_CLEAR) || bus.clr);
        end
    end

    // rd_X=0 returns the address itself (decoder debug path).
    always_comb begin
        data_a = '0;
        if (!busy) begin
            if (bus.rd_a) begin
                data_a = mem[bus.reg_a];
`ifdef REG_FILE_BYPASS_EN
                if (bus.wr && !bus.clr && (bus.reg_a == bus.reg_in)) begin
                    data_a = bus.data_in;
                end
`endif
            end else begin
                data_a = SIZE'(bus.reg_a);
            end
        end
    end

    always_comb begin
        data_b = '0;
        if (!busy) begin
            if (bus.rd_b) begin
                data_b = mem[bus.reg_b];
`ifdef REG_FILE_BYPASS_EN
                if (bus.wr && !bus.clr && (bus.reg_b == bus.reg_in)) begin
                    data_b = bus.data_in;
                end
`endif
            end else begin
                data_b = SIZE'(bus.reg_b);
            end
        end
    end

    assign bus.data_a    = data_a;
    assign bus.data_b    = data_b;
    assign bus.busy      = busy;
    assign bus.wr_drop   = wr_drop_q;
    assign bus.dbg_state = state;
    assign bus.dbg_ptr   = ptr;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp
// Self-checking bench for reg_file_mp (NUMRF=2, SIZE=8). Honours
// REG_FILE_BYPASS_EN in its reference model.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int NUMRF = 2;
    localparam int SIZE  = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    reg_file_if #(.NUMRF(NUMRF), .SIZE(SIZE)) bus ();

    reg_file_mp #(.NUMRF(NUMRF), .SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [SIZE-1:0] model_mem [DEPTH];
    logic [SIZE-1:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference read: zero while clearing, address on the debug path,
    // otherwise stored contents (or forwarded write data when compiled in).
    function automatic logic [SIZE-1:0] model_read(input bit busy_m, input bit rd,
                                                   input logic [NUMRF-1:0] a);
        if (busy_m) return '0;
        if (!rd) return SIZE'(a);
`ifdef REG_FILE_BYPASS_EN
        if (bus.wr && !bus.clr && a == bus.reg_in) return bus.data_in;
`endif
        return model_mem[a];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.clr = 0; bus.wr = 0; bus.reg_in = '0; bus.data_in = '0;
        bus.rd_a = 1; bus.rd_b = 1; bus.reg_a = '0; bus.reg_b = '0;
    endtask

    task automatic do_write(input logic [NUMRF-1:0] a, input logic [SIZE-1:0] d);
        bus.wr = 1; bus.reg_in = a; bus.data_in = d;
        tick();
        bus.wr = 0;
        model_mem[a] = d;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (!bus.busy) break;
            cnt++;
            tick();
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cnt;
        drive_idle();
        rst_n = 0;
        repeat (3) tick();
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus.busy); else n_pass++;
        n_checks++; if (bus.wr_drop !== 1'b0) $display("FAIL reset_wr_drop: got %b want 0", bus.wr_drop); else n_pass++;
        n_checks++; if (bus.data_a !== 8'h00 || bus.data_b !== 8'h00)
            $display("FAIL reset_data: got %h/%h want 00/00", bus.data_a, bus.data_b); else n_pass++;
        n_checks++; if (bus.dbg_state !== RF_CLEAR || bus.dbg_ptr !== 2'd0)
            $display("FAIL reset_state: got %0d/%0d want CLEAR/0", bus.dbg_state, bus.dbg_ptr); else n_pass++;
        rst_n = 1;
        count_busy(cnt);
        n_checks++; if (cnt !== DEPTH) $display("FAIL reset_busy_len: got %0d want %0d", cnt, DEPTH); else n_pass++;
        clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            bus.reg_a = NUMRF'(i); bus.reg_b = NUMRF'(DEPTH - 1 - i);
            #1;
            exp_q.push_back(model_read(0, 1, bus.reg_a));
            exp_q.push_back(model_read(0, 1, bus.reg_b));
            n_checks++; if (bus.data_a !== exp_q.pop_front()) $display("FAIL reset_zero_a%0d: got %h want 00", i, bus.data_a); else n_pass++;
            n_checks++; if (bus.data_b !== exp_q.pop_front()) $display("FAIL reset_zero_b%0d: got %h want 00", i, bus.data_b); else n_pass++;
        end
    endtask

    task automatic test_write_dual();
        logic [SIZE-1:0] e;
        bus.rd_a = 1; bus.rd_b = 1; bus.reg_a = 2; bus.reg_b = 2;
        bus.wr = 1; bus.reg_in = 2; bus.data_in = 8'hA5;
        #1;
        e = model_read(0, 1, 2);
        n_checks++; if (bus.data_a !== e || bus.data_b !== e)
            $display("FAIL wr_same_cycle: got %h/%h want %h", bus.data_a, bus.data_b, e); else n_pass++;
        tick();
        bus.wr = 0;
        model_mem[2] = 8'hA5;
        #1;
        n_checks++; if (bus.data_a !== 8'hA5 || bus.data_b !== 8'hA5)
            $display("FAIL wr_next_cycle: got %h/%h want a5", bus.data_a, bus.data_b); else n_pass++;
    endtask

    task automatic test_debug_path();
        bus.rd_a = 0; bus.reg_a = 3; bus.rd_b = 0; bus.reg_b = 1;
        #1;
        n_checks++; if (bus.data_a !== 8'h03) $display("FAIL dbg_a: got %h want 03", bus.data_a); else n_pass++;
        n_checks++; if (bus.data_b !== 8'h01) $display("FAIL dbg_b: got %h want 01", bus.data_b); else n_pass++;
        bus.rd_a = 1; bus.rd_b = 1;
    endtask

    task automatic test_write_busy();
        drive_idle();
        do_write(0, 8'h5A);
        bus.clr = 1;
        tick();                        // clear cycle 1
        bus.clr = 0; bus.rd_a = 0; bus.reg_a = 3;
        #1;
        n_checks++; if (bus.busy !== 1'b1 || bus.data_a !== 8'h00)
            $display("FAIL busy_rise: got busy=%b data_a=%h want 1/00", bus.busy, bus.data_a); else n_pass++;
        bus.rd_a = 1;
        tick();                        // clear cycle 2
        bus.wr = 1; bus.reg_in = 0; bus.data_in = 8'h3C;
        tick();                        // clear cycle 3
        bus.wr = 0;
        n_checks++; if (bus.wr_drop !== 1'b1) $display("FAIL drop_pulse: got %b want 1", bus.wr_drop); else n_pass++;
        tick();                        // clear cycle 4
        n_checks++; if (bus.wr_drop !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL drop_end: got drop=%b busy=%b want 0/1", bus.wr_drop, bus.busy); else n_pass++;
        tick();
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL busy_fall: got %b want 0", bus.busy); else n_pass++;
        clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            bus.reg_a = NUMRF'(i); bus.reg_b = NUMRF'(i);
            #1;
            n_checks++; if (bus.data_a !== model_mem[i] || bus.data_b !== model_mem[i])
                $display("FAIL busy_wr_zero%0d: got %h/%h want 00", i, bus.data_a, bus.data_b); else n_pass++;
        end
    endtask

    task automatic test_clr_with_write();
        int cnt;
        logic [SIZE-1:0] pre [DEPTH];
        pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33; pre[3] = 8'h44;
        drive_idle();
        for (int i = 0; i < DEPTH; i++) do_write(NUMRF'(i), pre[i]);
        for (int i = 0; i < DEPTH; i++) begin
            bus.reg_a = NUMRF'(i);
            #1;
            n_checks++; if (bus.data_a !== pre[i]) $display("FAIL preload%0d: got %h want %h", i, bus.data_a, pre[i]); else n_pass++;
        end
        bus.clr = 1; bus.wr = 1; bus.reg_in = 0; bus.data_in = 8'hFF;
        tick();
        bus.clr = 0; bus.wr = 0;
        n_checks++; if (bus.wr_drop !== 1'b1) $display("FAIL clr_wr_drop: got %b want 1", bus.wr_drop); else n_pass++;
        count_busy(cnt);
        n_checks++; if (cnt !== DEPTH) $display("FAIL clr_busy_len: got %0d want %0d", cnt, DEPTH); else n_pass++;
        clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            bus.reg_a = NUMRF'(i); bus.reg_b = NUMRF'(i);
            #1;
            n_checks++; if (bus.data_a !== model_mem[i] || bus.data_b !== model_mem[i])
                $display("FAIL clr_zero%0d: got %h/%h want 00", i, bus.data_a, bus.data_b); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        drive_idle();
        bus.clr = 1;
        tick();                        // clear cycle 1
        bus.clr = 0;
        tick();                        // clear cycle 2
        n_checks++; if (bus.dbg_ptr !== 2'd1) $display("FAIL mid_ptr: got %0d want 1", bus.dbg_ptr); else n_pass++;
        rst_n = 0; bus.wr = 1; bus.reg_in = 2; bus.data_in = 8'h77;
        tick();
        n_checks++; if (bus.dbg_ptr !== 2'd0 || bus.wr_drop !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL mid_reset: got ptr=%0d drop=%b busy=%b want 0/0/1", bus.dbg_ptr, bus.wr_drop, bus.busy); else n_pass++;
        rst_n = 1; bus.wr = 0;
        count_busy(cnt);
        n_checks++; if (cnt !== DEPTH) $display("FAIL mid_busy_len: got %0d want %0d", cnt, DEPTH); else n_pass++;
        clear_model();
        bus.reg_a = 2;
        #1;
        n_checks++; if (bus.data_a !== model_mem[2]) $display("FAIL mid_entry2: got %h want 00", bus.data_a); else n_pass++;
    endtask

    task automatic test_random_traffic();
        logic [SIZE-1:0] ea, eb;
        drive_idle();
        for (int n = 0; n < 150; n++) begin
            bus.wr      = ($urandom_range(0, 1) == 1);
            bus.reg_in  = NUMRF'($urandom_range(0, DEPTH - 1));
            bus.data_in = SIZE'($urandom_range(0, 255));
            bus.rd_a    = ($urandom_range(0, 3) != 0);
            bus.rd_b    = ($urandom_range(0, 3) != 0);
            bus.reg_a   = NUMRF'($urandom_range(0, DEPTH - 1));
            bus.reg_b   = NUMRF'($urandom_range(0, DEPTH - 1));
            #1;
            exp_q.push_back(model_read(0, bus.rd_a, bus.reg_a));
            exp_q.push_back(model_read(0, bus.rd_b, bus.reg_b));
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            n_checks++; if (bus.data_a !== ea) $display("FAIL rand_a[%0d]: got %h want %h", n, bus.data_a, ea); else n_pass++;
            n_checks++; if (bus.data_b !== eb) $display("FAIL rand_b[%0d]: got %h want %h", n, bus.data_b, eb); else n_pass++;
            if (bus.wr) model_mem[bus.reg_in] = bus.data_in;
            tick();
            n_checks++; if (bus.wr_drop !== 1'b0) $display("FAIL rand_drop[%0d]: got %b want 0", n, bus.wr_drop); else n_pass++;
        end
        drive_idle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_write_dual();
        test_debug_path();
        test_write_busy();
        test_clr_with_write();
        test_reset_mid_clear();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised two-read/one-write register file for the Femto datapath, replacing the single-port register file. It adds a second asynchronous read port and a synchronous active-low reset. On reset release and on explicit request, a hardware clear sequencer zeroes every entry. Write-to-read forwarding is available as a compile-time option. It sits between the instruction decoder (addresses and enables) and the ALU operand muxes.

## Interface
- NUMRF, default 2: address width in bits; DEPTH = 2**NUMRF entries.
- SIZE, default 8: data width in bits; SIZE must be at least NUMRF.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
- clr  in  1  request to re-run the clear sequence.
- wr  in  1  write enable.
- reg_in  in  NUMRF  write address.
- data_in  in  SIZE  write data.
- rd_a, rd_b  in  1  read enables for ports A and B.
- reg_a, reg_b  in  NUMRF  read addresses.
- data_a, data_b  out  SIZE  combinational read data.
- busy  out  1  registered; 1 while the clear sequence runs.
- wr_drop  out  1  registered one-cycle pulse flagging a discarded write.

## Operation
- Storage is DEPTH x SIZE flops. There is no memory macro.
- FSM states:
  - CLEAR: the pointer ptr walks 0..DEPTH-1, writing zero to entry ptr each cycle.
  - IDLE: normal operation.
- While rst_n=0:
  - state=CLEAR, ptr=0, busy=1, wr_drop=0.
  - No storage write occurs.
  - Entry contents are unspecified until the clear completes.
- CLEAR behaviour:
  - Each cycle: entry[ptr] <= 0, then ptr++.
  - When ptr==DEPTH-1 the state goes to IDLE and busy falls on the same edge.
- IDLE with clr=1: next state CLEAR, ptr=0, busy=1.
- clr=1 during CLEAR restarts the walk with ptr=0.
- Writes in IDLE with wr=1 and clr=0: entry[reg_in] <= data_in on the edge.
- Discarded writes:
  - A write is discarded when wr=1 and either state==CLEAR or clr=1 in the same cycle (clr has priority).
  - wr_drop=1 on the following cycle.
  - Otherwise wr_drop=0.
- Read port X (A or B):
  - busy=1: data_X = 0, regardless of rd_X.
  - rd_X=1: data_X = entry[reg_X].
  - rd_X=0: data_X = reg_X zero-extended to SIZE. This is the decoder debug path, kept from the previous generation.
- Both ports may read the same address. There is no port conflict.

## Timing
- Write latency is 1 cycle. Data is visible on the read ports in the cycle after the write edge, or in the same cycle when forwarding is compiled in.
- Read latency is 0 cycles (combinational from address to data).
- Clear duration:
  - busy rises one edge after clr, or immediately with rst_n=0.
  - busy stays high for exactly DEPTH cycles after rst_n deasserts or clr is sampled.
  - The first accepted write is on edge DEPTH+1 after deassertion.
- Reset asserted mid-clear or mid-write: the next edge forces CLEAR/ptr=0, and any write that edge is discarded without a wr_drop pulse.
- Reset values:
  - busy=1.
  - wr_drop=0.
  - data_a/data_b = 0, because busy=1.

## Configuration
- REG_FILE_BYPASS_EN defined: in IDLE, when wr=1, clr=0, rd_X=1 and reg_X==reg_in, data_X = data_in in the same cycle. This applies independently to each port.
- REG_FILE_BYPASS_EN undefined: data_X returns the stored value until the write edge, with no forwarding logic.
- The macro has no effect while busy=1 or when rd_X=0.

## Structure
- reg_file_pkg holds:
  - the state typedef (RF_IDLE, RF_CLEAR);
  - the DEPTH helper function;
  - the default NUMRF/SIZE constants.
- Sub-module reg_file_clr_seq:
  - contains the FSM, ptr and busy;
  - outputs clr_we and clr_addr to the storage array.
- The top level holds the storage, the write mux (clear has priority over user writes), the read muxes and wr_drop.

## Test plan
1. Reset-release clear: hold rst_n=0 for 3 cycles, then release. Required: busy=1 for exactly 4 cycles, then 0, after which all four entries read 0x00 on A and B.
2. Write then dual read: write 0xA5 to entry 2, then read with reg_a=2 and reg_b=2. Required: both ports show 0xA5 the next cycle. With forwarding compiled in, they show 0xA5 in the write cycle itself.
3. Debug path: rd_a=0 with reg_a=3 gives data_a=0x03. rd_b=0 with reg_b=1 gives data_b=0x01.
4. Write during busy: assert wr with data_in=0x3C in the second clear cycle. Required: wr_drop pulses for one cycle and the entry reads 0x00 after the clear.
5. clr with a simultaneous write in IDLE: entries are preloaded with 0x11/0x22/0x33/0x44, then clr=1 and wr=1 (reg_in=0, data_in=0xFF). Required: wr_drop=1, busy high for 4 cycles, then every entry reads 0x00.
6. Reset mid-clear: pull rst_n low in clear cycle 2. Required: ptr restarts at 0 and busy stays high for 4 full cycles after release.
